mem_arbiter: RTL and testbench

Two-requester arbiter for the single-port 16-bit data memory. The processor control unit is requester 0; a program loader or debug port is requester 1. The block grants one requester at a time and drives the shared memory port with registered read/write strobes. It returns read data with a one-cycle valid pulse, so the memory never sees two outstanding transactions.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_arb_pick.sv | 19 +
 rtl/mem_arbiter.sv | 80 ++++++++
 tb/tb_mem_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory arbiter
package mem_arb_pkg;
  localparam int DATA_W = 16;
  localparam int CNT_W = 2;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; round robin when MEM_ARB_ROUND_ROBIN_EN is defined, fixed priority otherwise
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       win,
  output logic       any_req
);
  assign any_req = |req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // ptr names the requester favoured on a tie, i.e. the one not granted last
  assign win = &req ? ptr : (req[1] ? REQ_AUX : REQ_CPU);
`else
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign win = req[0] ? REQ_CPU : REQ_AUX;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of two requesters access to a single-port memory, one transaction in flight
// Tie policy selected by MEM_ARB_ROUND_ROBIN_EN (round robin) or fixed priority to requester 0 when undefined
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [DATA_W-1:0] mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);
  state_t state, state_nx;
  logic win, win_q, any_req, we_q, ptr, take;
  logic [CNT_W-1:0] cnt;
  mem_arb_pick u_pick (.req({req1, req0}), .ptr(ptr), .win(win), .any_req(any_req));
  assign take = (state == IDLE) && any_req;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == IDLE)  ? (any_req ? ISSUE : IDLE) :
               (state == ISSUE) ? (we_q ? IDLE : WAIT) :
               (state == WAIT)  ? ((cnt == '0) ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rdata       <= '0;
      cnt         <= '0;
    end else begin
      if (take) begin
        win_q       <= win;
        we_q        <= win ? we1 : we0;
        mem_address <= win ? addr1 : addr0;
        if (win ? we1 : we0) mem_data_in <= win ? wdata1 : wdata0;
      end
      if (state == ISSUE) cnt <= CNT_LOAD;
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (state == WAIT && cnt == '0) rdata <= mem_data_out;
    end
  end
`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= REQ_CPU;
    else if (take) ptr <= ~win;
`else
  assign ptr = REQ_CPU;
`endif
  always_comb begin
    gnt0             = (state == ISSUE) && (win_q == REQ_CPU);
    gnt1             = (state == ISSUE) && (win_q == REQ_AUX);
    mem_read_enable  = (state == ISSUE) && !we_q;
    mem_write_enable = (state == ISSUE) && we_q;
    rvalid0          = (state == RESP) && (win_q == REQ_CPU);
    rvalid1          = (state == RESP) && (win_q == REQ_AUX);
    busy             = state != IDLE;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (read latency 1 and 3) against a transaction-timeline reference model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [1:0][1:0] req, we;
  logic [1:0][1:0][15:0] addr, wdata;
  logic [1:0] gnt0, gnt1, rv0, rv1, busy, mre, mwe;
  logic [1:0][15:0] rdata, maddr, mdin, mdout;
  function automatic int rl(int i);
    return i ? 3 : 1;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : inst
    logic [15:0] smem [64] = '{default: 16'h0};
    int pend = 0;
    logic [5:0] paddr = 6'd0;
    mem_arbiter #(.READ_LATENCY(g ? 3 : 1)) dut (
      .clk(clk), .reset(reset),
      .req0(req[g][0]), .req1(req[g][1]), .we0(we[g][0]), .we1(we[g][1]),
      .addr0(addr[g][0]), .addr1(addr[g][1]), .wdata0(wdata[g][0]), .wdata1(wdata[g][1]),
      .gnt0(gnt0[g]), .gnt1(gnt1[g]), .rvalid0(rv0[g]), .rvalid1(rv1[g]),
      .rdata(rdata[g]), .busy(busy[g]), .mem_address(maddr[g]),
      .mem_read_enable(mre[g]), .mem_write_enable(mwe[g]),
      .mem_data_in(mdin[g]), .mem_data_out(mdout[g])
    );
    // memory presents valid data only in the cycle exactly READ_LATENCY after the strobe
    always @(posedge clk) begin
      if (mwe[g]) smem[maddr[g][5:0]] <= mdin[g];
      if (mre[g]) begin
        pend  <= rl(g);
        paddr <= maddr[g][5:0];
      end else if (pend != 0) pend <= pend - 1;
    end
    assign mdout[g] = (pend == 1) ? smem[paddr] : 16'hDEAD;
  end
  int n, checks, failures, ci, rnd_pct;
  bit tie_mode;
  int issue_c [2], end_c [2], rv_c [2];
  logic wn [2], wr [2], prio [2];
  logic [15:0] t_addr [2], t_data [2], t_rd [2], e_addr [2], e_din [2], e_rd [2];
  logic [15:0] rmem [2][64];
  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cycle=%0d got=%h exp=%h", tag, ci, n, got, exp);
    end
  endtask
  task automatic post(int i, int r, logic w, logic [15:0] a, logic [15:0] d);
    req[i][r] = 1'b1;
    we[i][r] = w;
    addr[i][r] = a;
    wdata[i][r] = d;
  endtask
  task automatic decide();
    logic w;
    for (int i = 0; i < 2; i++)
      if (!reset && n >= end_c[i] && (req[i][0] || req[i][1])) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w = (req[i][0] && req[i][1]) ? prio[i] : req[i][1];
        prio[i] = !w;
`else
        w = !req[i][0];
`endif
        wn[i] = w;
        wr[i] = we[i][w];
        t_addr[i] = addr[i][w];
        t_data[i] = wdata[i][w];
        issue_c[i] = n + 1;
        end_c[i] = wr[i] ? n + 2 : n + 3 + rl(i);
        rv_c[i] = wr[i] ? -1 : n + 2 + rl(i);
      end
  endtask
  task automatic compare_all();
    logic iss, rs;
    for (int i = 0; i < 2; i++) begin
      ci = i;
      if (reset) begin
        issue_c[i] = -1; end_c[i] = 0; rv_c[i] = -1; prio[i] = 1'b0;
        wn[i] = 1'b0; wr[i] = 1'b0;
        e_addr[i] = '0; e_din[i] = '0; e_rd[i] = '0; req[i] = '0;
      end else begin
        if (n == issue_c[i]) begin
          e_addr[i] = t_addr[i];
          if (wr[i]) begin
            e_din[i] = t_data[i];
            rmem[i][t_addr[i][5:0]] = t_data[i];
          end else t_rd[i] = rmem[i][t_addr[i][5:0]];
        end
        if (n == rv_c[i]) e_rd[i] = t_rd[i];
      end
      iss = !reset && n == issue_c[i];
      rs = !reset && n == rv_c[i];
      check("gnt0", 16'(gnt0[i]), 16'(iss && !wn[i]));
      check("gnt1", 16'(gnt1[i]), 16'(iss && wn[i]));
      check("mem_re", 16'(mre[i]), 16'(iss && !wr[i]));
      check("mem_we", 16'(mwe[i]), 16'(iss && wr[i]));
      check("rvalid0", 16'(rv0[i]), 16'(rs && !wn[i]));
      check("rvalid1", 16'(rv1[i]), 16'(rs && wn[i]));
      check("busy", 16'(busy[i]), 16'(!reset && n >= issue_c[i] && n < end_c[i]));
      check("mem_addr", maddr[i], e_addr[i]);
      check("mem_din", mdin[i], e_din[i]);
      check("rdata", rdata[i], e_rd[i]);
      if (iss) begin
        req[i][wn[i]] = 1'b0;
        if (tie_mode) post(i, int'(wn[i]), 1'b1, addr[i][wn[i]], 16'($urandom));
      end
      if (!reset)
        for (int r = 0; r < 2; r++)
          if (!req[i][r] && $urandom_range(99) < rnd_pct)
            post(i, r, 1'($urandom_range(1)), 16'($urandom_range(63)), 16'($urandom));
    end
  endtask
  task automatic tick(bit rst_next);
    decide();
    @(posedge clk);
    #1 reset = rst_next;
    @(negedge clk);
    n++;
    compare_all();
  endtask
  task automatic run(int k);
    repeat (k) tick(1'b0);
  endtask
  task automatic post_both(int r, logic w, logic [15:0] a, logic [15:0] d);
    for (int i = 0; i < 2; i++) post(i, r, w, a, d);
  endtask
  initial begin
    n = 0; checks = 0; failures = 0; ci = 0; rnd_pct = 0; tie_mode = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 64; a++) rmem[i][a] = 16'h0;
    repeat (3) tick(1'b1);
    tick(1'b0);
    post_both(1, 1'b1, 16'h0010, 16'h1234); run(4);
    post_both(1, 1'b1, 16'h0005, 16'h00A5); run(4);
    post_both(0, 1'b0, 16'h0010, 16'h0); run(8);
    post_both(1, 1'b1, 16'h0020, 16'hBEEF); run(4);
    post_both(0, 1'b0, 16'h0020, 16'h0); run(8);
    post_both(1, 1'b0, 16'h0005, 16'h0); run(8);
    post_both(0, 1'b0, 16'h0010, 16'h0);
    for (int k = 0; k < 5 && n != issue_c[0]; k++) tick(1'b0);
    post_both(1, 1'b1, 16'h0030, 16'h5A5A); run(12);
    post_both(0, 1'b0, 16'h0020, 16'h0);
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    post_both(0, 1'b0, 16'h0005, 16'h0); run(8);
    tie_mode = 1'b1;
    post_both(0, 1'b1, 16'h0011, 16'h1111);
    post_both(1, 1'b1, 16'h0012, 16'h2222);
    run(12);
    tie_mode = 1'b0;
    req = '0; run(8);
    rnd_pct = 30; run(400);
    rnd_pct = 0;
    req = '0; run(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
